// File: rtl/updown_counter_ctrl.sv
// Up/down LED counter controller: debounced buttons, STOP/RUN/PAUSE FSM,
// prescaled count enable and a wrap pulse, all on a single clock.
// Optional build macro CNT_SATURATE_EN: the counter saturates at its limits,
// pulses wrap and drops to PAUSE instead of wrapping modulo 2^CNT_W.
module updown_counter_ctrl #(
    parameter int unsigned CNT_W     = 4,
    parameter int unsigned PRESC_MAX = 16777216,
    parameter int unsigned DB_CYCLES = 1000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn0,
    input  logic             btn1,
    output logic [CNT_W-1:0] S,
    output logic             led0,
    output logic             led1,
    output logic             wrap
);

    localparam int unsigned PRESC_W = (PRESC_MAX > 1) ? $clog2(PRESC_MAX) : 1;
    localparam int unsigned DB_W    = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam int unsigned NBTN    = 2;

    typedef enum logic [1:0] {
        ST_STOP  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_e;

    // Button path registers, index 0 = btn0 (direction), 1 = btn1 (run/pause)
    logic [NBTN-1:0] btn_raw;
    logic [NBTN-1:0] sync1_q;
    logic [NBTN-1:0] sync2_q;
    logic [NBTN-1:0] level_q;
    logic [NBTN-1:0] prev_q;
    logic [NBTN-1:0] press_q;
    logic [NBTN-1:0] armed_q;
    logic [DB_W-1:0] db_cnt_q [NBTN];
    logic [1:0]      warm_q;

    // Counter / FSM registers
    state_e             state_q;
    logic [PRESC_W-1:0] presc_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               dir_q;
    logic               run_q;
    logic               wrap_q;

    // Combinational helpers for the FSM
    logic               tick_c;
    logic               limit_c;
    logic               both_c;
    logic               sat_hit_c;
    logic [CNT_W-1:0]   step_d;
    logic [PRESC_W-1:0] presc_d;

    assign btn_raw = {btn1, btn0};

    // Synchronize, debounce and edge-detect both buttons. A button is only
    // armed once it has been seen released after reset, so a button held
    // through reset produces no press until it is released and pressed again.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            level_q <= '0;
            prev_q  <= '0;
            press_q <= '0;
            armed_q <= '0;
            warm_q  <= '0;
            for (int i = 0; i < NBTN; i++) begin
                db_cnt_q[i] <= '0;
            end
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            prev_q  <= level_q;
            if (warm_q != 2'd2) begin
                warm_q <= warm_q + 2'd1;
            end
            for (int i = 0; i < NBTN; i++) begin
                if (sync2_q[i] != level_q[i]) begin
                    if (db_cnt_q[i] == DB_W'(DB_CYCLES - 1)) begin
                        level_q[i]  <= sync2_q[i];
                        db_cnt_q[i] <= '0;
                    end else begin
                        db_cnt_q[i] <= db_cnt_q[i] + DB_W'(1);
                    end
                end else begin
                    db_cnt_q[i] <= '0;
                end
                press_q[i] <= level_q[i] & ~prev_q[i] & armed_q[i];
                if ((prev_q[i] && !level_q[i]) ||
                    (warm_q == 2'd2 && !level_q[i] && !sync2_q[i])) begin
                    armed_q[i] <= 1'b1;
                end
            end
        end
    end

    // Tick, next count value and limit detection for the current direction
    always_comb begin
        tick_c  = (state_q == ST_RUN) && (presc_q == PRESC_W'(PRESC_MAX - 1));
        presc_d = tick_c ? '0 : presc_q + PRESC_W'(1);
        step_d  = dir_q ? cnt_q + CNT_W'(1) : cnt_q - CNT_W'(1);
        limit_c = dir_q ? (cnt_q == '1) : (cnt_q == '0);
        both_c  = press_q[0] & press_q[1];
`ifdef CNT_SATURATE_EN
        sat_hit_c = tick_c & limit_c;
`else
        sat_hit_c = 1'b0;
`endif
    end

    // STOP/RUN/PAUSE state machine with registered counter and LEDs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_STOP;
            presc_q <= '0;
            cnt_q   <= '0;
            dir_q   <= 1'b1;
            run_q   <= 1'b0;
            wrap_q  <= 1'b0;
        end else if (both_c) begin
            state_q <= ST_STOP;
            presc_q <= '0;
            cnt_q   <= '0;
            run_q   <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            wrap_q <= 1'b0;
            if (press_q[0]) begin
                dir_q <= ~dir_q;
            end
            case (state_q)
                ST_STOP: begin
                    if (press_q[1]) begin
                        state_q <= ST_RUN;
                        run_q   <= 1'b1;
                    end
                end
                ST_RUN: begin
                    presc_q <= presc_d;
                    if (tick_c) begin
`ifdef CNT_SATURATE_EN
                        if (limit_c) begin
                            wrap_q <= 1'b1;
                        end else begin
                            cnt_q <= step_d;
                        end
`else
                        cnt_q  <= step_d;
                        wrap_q <= limit_c;
`endif
                    end
                    if (press_q[1] || sat_hit_c) begin
                        state_q <= ST_PAUSE;
                        run_q   <= 1'b0;
                    end
                end
                ST_PAUSE: begin
                    if (press_q[1]) begin
                        state_q <= ST_RUN;
                        run_q   <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_STOP;
                    run_q   <= 1'b0;
                end
            endcase
        end
    end

    assign S    = cnt_q;
    assign led0 = dir_q;
    assign led1 = run_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_updown_counter_ctrl.sv
// Bench for updown_counter_ctrl: directed scenarios plus randomized button
// traffic, compared every cycle against a cycle-level behavioural model.
module tb_updown_counter_ctrl;

    localparam int unsigned CNT_W     = 4;
    localparam int unsigned PRESC_MAX = 4;
    localparam int unsigned DB_CYCLES = 3;
    localparam int          MODV      = 1 << CNT_W;
    localparam int          LAT       = DB_CYCLES + 3;
    localparam int          MAXE      = 16384;
    localparam int          M_STOP    = 0;
    localparam int          M_RUN     = 1;
    localparam int          M_PAUSE   = 2;

    logic             clk  = 1'b0;
    logic             rst  = 1'b1;
    logic             btn0 = 1'b0;
    logic             btn1 = 1'b0;
    logic [CNT_W-1:0] S;
    logic             led0;
    logic             led1;
    logic             wrap;

    updown_counter_ctrl #(
        .CNT_W    (CNT_W),
        .PRESC_MAX(PRESC_MAX),
        .DB_CYCLES(DB_CYCLES)
    ) dut (
        .clk (clk),
        .rst (rst),
        .btn0(btn0),
        .btn1(btn1),
        .S   (S),
        .led0(led0),
        .led1(led1),
        .wrap(wrap)
    );

    always #5 clk = ~clk;

    // Model state: press actions are scheduled by edge index
    bit act0 [MAXE];
    bit act1 [MAXE];
    int ecnt    = 0;
    int m_st    = M_STOP;
    int m_s     = 0;
    int m_presc = 0;
    bit m_dir   = 1'b1;
    bit m_wrap  = 1'b0;
    int total   = 0;
    int bad     = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d (edge %0d)", tag, obs, exp, ecnt);
        end
    endtask

    // One clock edge of the behavioural model
    task automatic model_edge();
        bit p0;
        bit p1;
        bit tick;
        bit hit;
        p0  = act0[ecnt];
        p1  = act1[ecnt];
        hit = 1'b0;
        if (rst) begin
            m_st = M_STOP; m_s = 0; m_presc = 0; m_dir = 1'b1; m_wrap = 1'b0;
        end else if (p0 && p1) begin
            m_st = M_STOP; m_s = 0; m_presc = 0; m_wrap = 1'b0;
        end else begin
            m_wrap = 1'b0;
            if (m_st == M_RUN) begin
                tick    = (m_presc == PRESC_MAX - 1);
                m_presc = (m_presc + 1) % PRESC_MAX;
                if (tick) begin
`ifdef CNT_SATURATE_EN
                    if ((m_dir && m_s == MODV - 1) || (!m_dir && m_s == 0)) begin
                        m_wrap = 1'b1;
                        hit    = 1'b1;
                    end else begin
                        m_s = m_dir ? m_s + 1 : m_s - 1;
                    end
`else
                    m_wrap = m_dir ? (m_s == MODV - 1) : (m_s == 0);
                    m_s    = m_dir ? (m_s + 1) % MODV : (m_s + MODV - 1) % MODV;
`endif
                end
                if (p1 || hit) m_st = M_PAUSE;
            end else if (p1) begin
                m_st = M_RUN;
            end
            if (p0) m_dir = !m_dir;
        end
        ecnt++;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("S", 32'(S), 32'(m_s));
        check("led0", 32'(led0), 32'(m_dir));
        check("led1", 32'(led1), 32'(m_st == M_RUN));
        check("wrap", 32'(wrap), 32'(m_wrap));
    endtask

    // Raise the chosen buttons at a negedge, hold, release, idle for gap
    task automatic press(input bit b0, input bit b1, input int hold, input int gap);
        int idx;
        idx = ecnt + LAT;
        if (hold >= int'(DB_CYCLES) && idx < MAXE) begin
            if (b0) act0[idx] = 1'b1;
            if (b1) act1[idx] = 1'b1;
        end
        btn0 = b0;
        btn1 = b1;
        repeat (hold) step();
        btn0 = 1'b0;
        btn1 = 1'b0;
        repeat (gap) step();
    endtask

    task automatic run_until_s(input int v);
        int n;
        n = 0;
        while (m_s != v && n < 300) begin
            step();
            n++;
        end
        check("reach_S", 32'(S), 32'(v));
    endtask

    initial begin
        int r;
        int hold;
        int gap;

        // Reset then idle
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        repeat (50) step();

        // Two-cycle glitch is rejected
        press(1'b0, 1'b1, 2, 12);

        // Start counting and run through a full wrap
        press(1'b0, 1'b1, 10, 0);
        repeat (70) step();

        // Reverse direction, pause, resume
        run_until_s(3);
        press(1'b1, 1'b0, DB_CYCLES + 2, 30);
        press(1'b0, 1'b1, DB_CYCLES + 2, 40);
        press(1'b0, 1'b1, DB_CYCLES + 2, 30);

        // Simultaneous presses force STOP
        run_until_s(9);
        press(1'b1, 1'b1, DB_CYCLES + 2, 20);

        // Button held across reset must not start the counter
        btn1 = 1'b1;
        rst  = 1'b1;
        step();
        rst  = 1'b0;
        repeat (20) step();
        btn1 = 1'b0;
        repeat (12) step();

        // Reset in the middle of a run
        press(1'b0, 1'b1, DB_CYCLES + 1, 0);
        run_until_s(7);
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (10) step();

        // Randomized button traffic
        for (int k = 0; k < 40; k++) begin
            r    = int'($urandom_range(0, 9));
            hold = int'($urandom_range(DB_CYCLES, DB_CYCLES + 6));
            gap  = int'($urandom_range(DB_CYCLES + 3, DB_CYCLES + 25));
            if (r <= 3)      press(1'b0, 1'b1, hold, gap);
            else if (r <= 6) press(1'b1, 1'b0, hold, gap);
            else if (r == 7) press(1'b1, 1'b1, hold, gap);
            else begin
                hold = int'($urandom_range(1, DB_CYCLES - 1));
                if (r == 8) press(1'b1, 1'b0, hold, gap);
                else        press(1'b0, 1'b1, hold, gap);
            end
        end
        repeat (40) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
